// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream sink: FSM state encoding (matches
// the companion master) and pointer/index width helpers.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        WRITE_FIFO = 2'b01,
        DRAIN      = 2'b10
    } state_t;

    // Width able to hold 0..n inclusive (pointers and packet length).
    function automatic int unsigned ptr_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Width needed to address n storage entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_stream_sink_if.sv
// AXI4-Stream handshake/data bundle between a stream master and this sink.
interface axis_stream_sink_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                      TREADY;
    logic [DATA_WIDTH-1:0]     TDATA;
    logic [DATA_WIDTH/8-1:0]   TSTRB;
    logic                      TLAST;
    logic                      TVALID;

    modport master (
        output TDATA,
        output TSTRB,
        output TLAST,
        output TVALID,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TSTRB,
        input  TLAST,
        input  TVALID,
        output TREADY
    );

endinterface

// File: rtl/axis_sink_buf.sv
// Packet buffer: register array with a byte-strobe-masked write port and a
// registered pop-style read port (1-cycle latency, one-cycle valid pulse).
module axis_sink_buf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned IDX_WIDTH  = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [IDX_WIDTH-1:0]    i_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
    input  logic                    i_rd_en,
    input  logic [IDX_WIDTH-1:0]    i_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_rd_valid
);

    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_masked;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    // Zero every byte lane whose strobe bit is clear.
    always_comb begin
        w_masked = '0;
        for (int unsigned b = 0; b < LANES; b++) begin
            if (i_wr_strb[b]) begin
                w_masked[b*8 +: 8] = i_wr_data[b*8 +: 8];
            end
        end
    end

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= w_masked;
        end
    end

    // Registered read: data holds between pops, valid pulses per pop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= r_mem[i_rd_addr];
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/axis_stream_sink.sv
// AXI4-Stream sink: receives one packet of up to NUMBER_OF_INPUT_WORDS beats,
// checks TLAST framing and the 1,2,3,... data pattern, then hands the stored
// packet out through a pop-style read port.
module axis_stream_sink
    import axis_pkg::*;
#(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH  = 32,
    parameter int unsigned NUMBER_OF_INPUT_WORDS = 8
) (
    input  logic                                          S_AXIS_ACLK,
    input  logic                                          S_AXIS_ARESET,
    axis_stream_sink_if.slave                             S_AXIS,
    input  logic                                          rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]               rd_data,
    output logic                                          rd_valid,
    output logic                                          pkt_ready,
    output logic [ptr_width(NUMBER_OF_INPUT_WORDS)-1:0]   pkt_len,
    output logic                                          err_early_last,
    output logic                                          err_no_last,
    output logic                                          err_seq
);

    localparam int unsigned DW = C_S_AXIS_TDATA_WIDTH;
    localparam int unsigned N  = NUMBER_OF_INPUT_WORDS;
    localparam int unsigned PW = ptr_width(N);
    localparam int unsigned IW = idx_width(N);

    localparam logic [PW-1:0] DEPTH_P  = PW'(N);
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_pkt_len;
    logic            r_err_early_last;
    logic            r_err_no_last;
    logic            r_err_seq;

    logic            w_tready;
    logic            w_beat;
    logic            w_at_last_idx;
    logic            w_term;
    logic            w_pop;
    logic            w_last_pop;
    logic [DW-1:0]   w_expect;

    // Ready decodes from registered state only; async reset forces IDLE,
    // so ready drops the moment reset asserts.
    assign w_tready      = (r_state == WRITE_FIFO) && (r_wr_ptr < DEPTH_P);
    assign w_beat        = S_AXIS.TVALID && w_tready;
    assign w_at_last_idx = (r_wr_ptr == LAST_IDX);
    assign w_term        = w_beat && (S_AXIS.TLAST || w_at_last_idx);
    assign w_pop         = (r_state == DRAIN) && rd_en && (r_rd_ptr != r_pkt_len);
    assign w_last_pop    = w_pop && (r_rd_ptr == (r_pkt_len - PW'(1)));
    assign w_expect      = DW'(r_wr_ptr) + DW'(1);

    // FSM state register.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:       w_state_next = WRITE_FIFO;
            WRITE_FIFO: if (w_term) w_state_next = DRAIN;
            DRAIN:      if (w_last_pop) w_state_next = IDLE;
            default:    w_state_next = IDLE;
        endcase
    end

    // Write/read pointers and stored length; the final pop clears them all.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pkt_len <= '0;
        end else if (w_last_pop) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pkt_len <= '0;
        end else begin
            if (w_beat) begin
                r_wr_ptr  <= r_wr_ptr + PW'(1);
                r_pkt_len <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Sticky framing and data-pattern error flags, cleared only by reset.
    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_err_early_last <= 1'b0;
            r_err_no_last    <= 1'b0;
            r_err_seq        <= 1'b0;
        end else if (w_beat) begin
            if (S_AXIS.TLAST && (r_wr_ptr < LAST_IDX)) begin
                r_err_early_last <= 1'b1;
            end
            if (w_at_last_idx && !S_AXIS.TLAST) begin
                r_err_no_last <= 1'b1;
            end
            if (S_AXIS.TDATA != w_expect) begin
                r_err_seq <= 1'b1;
            end
        end
    end

    axis_sink_buf #(
        .DATA_WIDTH (DW),
        .DEPTH      (N),
        .IDX_WIDTH  (IW)
    ) u_buf (
        .i_clk      (S_AXIS_ACLK),
        .i_rst      (S_AXIS_ARESET),
        .i_wr_en    (w_beat),
        .i_wr_addr  (r_wr_ptr[IW-1:0]),
        .i_wr_data  (S_AXIS.TDATA),
        .i_wr_strb  (S_AXIS.TSTRB),
        .i_rd_en    (w_pop),
        .i_rd_addr  (r_rd_ptr[IW-1:0]),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid)
    );

    assign S_AXIS.TREADY  = w_tready;
    assign pkt_ready      = (r_state == DRAIN);
    assign pkt_len        = r_pkt_len;
    assign err_early_last = r_err_early_last;
    assign err_no_last    = r_err_no_last;
    assign err_seq        = r_err_seq;

endmodule

// File: tb/tb_axis_stream_sink.sv
// Directed self-checking bench for axis_stream_sink (N=8, 32-bit data).
module tb_axis_stream_sink;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_len;
    logic        err_early_last;
    logic        err_no_last;
    logic        err_seq;

    int checks;
    int errors;

    axis_stream_sink_if #(.DATA_WIDTH(32)) s_axis ();

    axis_stream_sink #(
        .C_S_AXIS_TDATA_WIDTH  (32),
        .NUMBER_OF_INPUT_WORDS (8)
    ) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESET  (rst),
        .S_AXIS         (s_axis),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .pkt_ready      (pkt_ready),
        .pkt_len        (pkt_len),
        .err_early_last (err_early_last),
        .err_no_last    (err_no_last),
        .err_seq        (err_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat, wait (bounded) for ready, and let it be taken.
    task automatic beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        s_axis.TVALID = 1'b1;
        s_axis.TDATA  = data;
        s_axis.TSTRB  = strb;
        s_axis.TLAST  = last;
        n = 0;
        while (!s_axis.TREADY && n < 20) begin
            tick();
            n++;
        end
        chk("tready_wait", {31'd0, s_axis.TREADY}, 32'd1);
        tick();
    endtask

    task automatic idle_bus();
        s_axis.TVALID = 1'b0;
        s_axis.TLAST  = 1'b0;
        s_axis.TDATA  = '0;
        s_axis.TSTRB  = 4'hF;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rd_en  = 1'b0;
        idle_bus();

        // Reset state
        tick();
        tick();
        chk("rst_tready",    {31'd0, s_axis.TREADY}, 32'd0);
        chk("rst_rd_data",   rd_data, 32'd0);
        chk("rst_rd_valid",  {31'd0, rd_valid}, 32'd0);
        chk("rst_pkt_len",   {28'd0, pkt_len}, 32'd0);
        chk("rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
        chk("rst_errs",      {29'd0, err_early_last, err_no_last, err_seq}, 32'd0);
        rst = 1'b0;

        // Nominal: 1..8 streamed back to back, TLAST on beat 8
        tick();
        chk("nom_tready_up", {31'd0, s_axis.TREADY}, 32'd1);
        cyc = 0;
        s_axis.TVALID = 1'b1;
        s_axis.TSTRB  = 4'hF;
        for (int i = 1; i <= 8; i++) begin
            s_axis.TDATA = 32'(i);
            s_axis.TLAST = (i == 8);
            if (i > 1) chk("nom_tready_hold", {31'd0, s_axis.TREADY}, 32'd1);
            tick();
            cyc++;
        end
        idle_bus();
        chk("nom_cycles",    32'(cyc), 32'd8);
        chk("nom_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        chk("nom_pkt_len",   {28'd0, pkt_len}, 32'd8);
        chk("nom_tready_dn", {31'd0, s_axis.TREADY}, 32'd0);
        chk("nom_errs",      {29'd0, err_early_last, err_no_last, err_seq}, 32'd0);
        rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("nom_pop_valid", {31'd0, rd_valid}, 32'd1);
            chk("nom_pop_data",  rd_data, 32'(i));
        end
        rd_en = 1'b0;
        chk("nom_idle", {31'd0, pkt_ready}, 32'd0);
        chk("nom_len_clr", {28'd0, pkt_len}, 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("rd_outside_drain", {31'd0, rd_valid}, 32'd0);

        // Gaps: TVALID toggled between beats; ready must stay up
        for (int i = 1; i <= 8; i++) begin
            beat(32'(i), 4'hF, i == 8);
            s_axis.TVALID = 1'b0;
            if (i < 8) begin
                chk("gap_tready", {31'd0, s_axis.TREADY}, 32'd1);
                tick();
            end
        end
        idle_bus();
        chk("gap_pkt_len", {28'd0, pkt_len}, 32'd8);
        for (int i = 1; i <= 8; i++) pop_chk("gap_pop", 32'(i));
        chk("gap_idle", {31'd0, pkt_ready}, 32'd0);

        // Early TLAST on beat 5
        for (int i = 1; i <= 5; i++) beat(32'(i), 4'hF, i == 5);
        idle_bus();
        chk("early_flag",    {31'd0, err_early_last}, 32'd1);
        chk("early_nolast",  {31'd0, err_no_last}, 32'd0);
        chk("early_seq",     {31'd0, err_seq}, 32'd0);
        chk("early_len",     {28'd0, pkt_len}, 32'd5);
        chk("early_ready",   {31'd0, pkt_ready}, 32'd1);
        for (int i = 1; i <= 5; i++) pop_chk("early_pop", 32'(i));
        chk("early_idle", {31'd0, pkt_ready}, 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("early_extra_pop", {31'd0, rd_valid}, 32'd0);

        // Missing TLAST plus a bad word at beat 3
        for (int i = 1; i <= 8; i++) beat((i == 3) ? 32'h7 : 32'(i), 4'hF, 1'b0);
        idle_bus();
        chk("nolast_flag", {31'd0, err_no_last}, 32'd1);
        chk("nolast_seq",  {31'd0, err_seq}, 32'd1);
        chk("nolast_len",  {28'd0, pkt_len}, 32'd8);
        chk("nolast_ready", {31'd0, pkt_ready}, 32'd1);
        for (int i = 1; i <= 8; i++) pop_chk("nolast_pop", (i == 3) ? 32'h7 : 32'(i));

        // Strobe masking: fresh reset so error flags start clean
        rst = 1'b1;
        tick();
        chk("rst2_errs", {29'd0, err_early_last, err_no_last, err_seq}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) beat(32'(i), (i == 1) ? 4'h0 : 4'hF, i == 8);
        idle_bus();
        chk("strb_seq", {31'd0, err_seq}, 32'd0);
        pop_chk("strb_pop0", 32'h0);
        for (int i = 2; i <= 8; i++) pop_chk("strb_pop", 32'(i));

        // Async reset mid-packet after 4 beats (beat 2 carries bad data)
        beat(32'd1, 4'hF, 1'b0);
        beat(32'd9, 4'hF, 1'b0);
        beat(32'd3, 4'hF, 1'b0);
        beat(32'd4, 4'hF, 1'b0);
        s_axis.TDATA = 32'd5;
        chk("mid_seq_set", {31'd0, err_seq}, 32'd1);
        chk("mid_tready",  {31'd0, s_axis.TREADY}, 32'd1);
        chk("mid_len",     {28'd0, pkt_len}, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tready", {31'd0, s_axis.TREADY}, 32'd0);
        chk("arst_errs",   {29'd0, err_early_last, err_no_last, err_seq}, 32'd0);
        chk("arst_len",    {28'd0, pkt_len}, 32'd0);
        idle_bus();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) beat(32'(i), 4'hF, i == 8);
        idle_bus();
        chk("post_len",  {28'd0, pkt_len}, 32'd8);
        chk("post_errs", {29'd0, err_early_last, err_no_last, err_seq}, 32'd0);
        for (int i = 1; i <= 8; i++) pop_chk("post_pop", 32'(i));
        chk("post_idle", {31'd0, pkt_ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_stream_sink.md
Name: axis_stream_sink

Overview:
- AXI4-Stream slave; the receiving end for the codebase's 8-word AXI-Stream master.
- Accepts one packet of up to NUMBER_OF_INPUT_WORDS beats into an internal buffer.
- Checks framing (TLAST position) and the master's incrementing data pattern (1, 2, 3, ...).
- Exposes the stored packet through a simple pop-style read port for firmware/test logic.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, TDATA width in bits; multiple of 8.
- NUMBER_OF_INPUT_WORDS, 8, buffer depth and expected packet length in beats; 2..64.

Ports:
- S_AXIS_ACLK  input  1  clock; all logic rising-edge.
- S_AXIS_ARESET  input  1  reset, asynchronous, active-high.
- S_AXIS_TREADY  output  1  slave ready.
- S_AXIS_TDATA  input  C_S_AXIS_TDATA_WIDTH  stream data.
- S_AXIS_TSTRB  input  C_S_AXIS_TDATA_WIDTH/8  byte qualifiers.
- S_AXIS_TLAST  input  1  last beat of packet.
- S_AXIS_TVALID  input  1  master valid.
- rd_en  input  1  pop one stored word; honoured only in DRAIN.
- rd_data  output  C_S_AXIS_TDATA_WIDTH  popped word, registered.
- rd_valid  output  1  one-cycle pulse qualifying rd_data.
- pkt_ready  output  1  high while in DRAIN.
- pkt_len  output  clog2(N+1)  beats stored for the current packet.
- err_early_last  output  1  sticky: TLAST seen before beat N-1.
- err_no_last  output  1  sticky: beat N-1 accepted without TLAST.
- err_seq  output  1  sticky: data pattern mismatch.

Behaviour:
- Reset (async assert, sync release): state=IDLE; wr_ptr=rd_ptr=0; TREADY=0; rd_data=0; rd_valid=0; pkt_len=0; all error flags 0. Buffer contents are don't-care.
- States: IDLE, WRITE_FIFO, DRAIN.
  - IDLE: go to WRITE_FIFO after one cycle, unconditionally.
  - WRITE_FIFO: go to DRAIN on the cycle after the terminating beat.
  - DRAIN: go to IDLE once pkt_len words have been popped.
- TREADY = (state==WRITE_FIFO) && (wr_ptr < N). It is decoded from registered state only, with no combinational path from TVALID.
- beat = TVALID && TREADY. On a beat:
  - The buffer stores TDATA[wr_ptr], with each byte lane whose TSTRB bit is 0 stored as 0x00.
  - wr_ptr increments.
  - pkt_len is updated to wr_ptr+1.
- Terminating beat: a beat with TLAST=1, or the beat at wr_ptr==N-1, whichever comes first.
- Framing errors:
  - TLAST=1 on a beat with wr_ptr < N-1 sets err_early_last. The packet ends short and pkt_len is less than N.
  - A beat at wr_ptr==N-1 with TLAST=0 sets err_no_last. The packet still ends at N beats, and later beats wait in IDLE/WRITE_FIFO of the next packet.
- Sequence check: expected value = wr_ptr+1, zero-extended to data width. Any beat whose TDATA (before strobe masking) differs sets err_seq.
- Error flags clear only on reset.
- TVALID without TREADY: nothing is stored and the master must hold. TVALID dropping mid-packet is legal; the block simply waits.
- Read port (DRAIN only):
  - rd_en=1 pops: rd_data <= buf[rd_ptr] and rd_valid <= 1 on the next edge, i.e. 1-cycle latency; rd_ptr increments.
  - rd_en outside DRAIN, or with rd_ptr==pkt_len, is ignored and rd_valid=0.
  - When the pop with rd_ptr==pkt_len-1 occurs, state goes to IDLE on the same edge. wr_ptr, rd_ptr and pkt_len are cleared, and rd_valid still pulses for that final word.
- Arithmetic: pointers and pkt_len are clog2(N+1) bits wide and cannot wrap within a packet.
- Reset mid-packet or mid-drain: TREADY drops asynchronously with reset assertion; the partial packet is discarded.

Decomposition:
- Shared package axis_pkg: state encoding (IDLE=2'b00, WRITE_FIFO=2'b01, DRAIN=2'b10, mirroring the master's encoding); the pointer-width function clog2(N+1).
- One natural sub-module: axis_sink_buf, a simple dual-port register array with a strobe-masked write port and a registered read port.
- FSM, pointers and checkers stay in the top.

Test Plan:
- Nominal: master sends 1..8 with TVALID=1, TREADY honoured, TLAST on beat 8 -> 8 beats in 8 cycles; pkt_ready=1, pkt_len=8, no errors. Eight rd_en pops return 1..8, one cycle after each rd_en, then IDLE.
- Backpressure/gaps: TVALID toggled 1,0,1,0 across the 8 beats -> identical stored data; TREADY never falls inside WRITE_FIFO before beat 8.
- Early TLAST: TLAST on beat 5 (data 1..5) -> err_early_last=1, pkt_len=5; 5 pops return 1..5, then IDLE.
- Missing TLAST and bad data: 8 beats, TLAST=0, beat 3 = 0x00000007 -> err_no_last=1, err_seq=1; stored word 2 = 0x00000007.
- Strobe masking: beat 1 TDATA=0x00000001 with TSTRB=4'b0000 -> pop returns 0x00000000, err_seq=0.
- Async reset mid-packet: assert S_AXIS_ARESET after beat 4 -> TREADY=0 immediately, flags=0. After release, a new 1..8 packet is received cleanly.
